// File: rtl/text_screen_gen_pkg.sv
// Shared timing constants, text-grid geometry and the cell-address helper
// for the 640x480 text screen generator.
package text_screen_gen_pkg;

    localparam int H_VISIBLE    = 640;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 752;
    localparam int V_VISIBLE    = 480;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 492;

    localparam int TEXT_COLS = 40;
    localparam int TEXT_ROWS = 30;
    localparam int CELLS     = TEXT_COLS * TEXT_ROWS;
    localparam int ADDR_W    = 11;
    localparam int CHAR_W    = 6;

    typedef struct packed {
        logic       horiz_sync;
        logic       vert_sync;
        logic       video_on;
        logic       frame_start;
        logic [2:0] font_row;
        logic [2:0] font_col;
    } timing_t;

    localparam timing_t TIMING_RESET = {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0};

    // row*40 + col built from row*32 + row*8 so no multiplier is inferred
    function automatic logic [ADDR_W-1:0] cell_address(input logic [4:0] row,
                                                       input logic [5:0] col);
        return {1'b0, row, 5'b00000} + {3'b000, row, 3'b000} + {5'b00000, col};
    endfunction

endpackage

// File: rtl/text_screen_gen_screen_ram.sv
// Character buffer: one write port, one synchronous read port; a read that
// collides with a write to the same cell returns the previous contents.
module screen_ram
    import text_screen_gen_pkg::*;
#(
    parameter int DEPTH = CELLS
) (
    input  logic              clock_25Mhz,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CHAR_W-1:0] rd_data
);

    logic [CHAR_W-1:0] mem [0:DEPTH-1];

    // Out-of-range addresses occur only during blanking, where the data is discarded
    always_ff @(posedge clock_25Mhz) begin
        if (wr_en && (wr_addr < ADDR_W'(DEPTH))) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_addr < ADDR_W'(DEPTH)) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/text_screen_gen.sv
// 640x480 text-mode timing generator: 40x30 cells of doubled 8x8 glyphs,
// every output registered one cycle after the scan counters.
module text_screen_gen
    import text_screen_gen_pkg::*;
#(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic        clock_25Mhz,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [5:0]  wr_col,
    input  logic [4:0]  wr_row,
    input  logic [5:0]  wr_char,
    output logic [5:0]  character_address,
    output logic [2:0]  font_row,
    output logic [2:0]  font_col,
    output logic        horiz_sync,
    output logic        vert_sync,
    output logic        video_on,
    output logic        frame_start
);

    localparam logic [9:0] H_MAX   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYN_S = 10'(H_SYNC_START);
    localparam logic [9:0] H_SYN_E = 10'(H_SYNC_END);
    localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYN_S = 10'(V_SYNC_START);
    localparam logic [9:0] V_SYN_E = 10'(V_SYNC_END);

    logic [9:0]        h_count;
    logic [9:0]        v_count;
    logic              h_wrap;
    timing_t           timing_q;
    logic              write_ok;
    logic [ADDR_W-1:0] write_addr;
    logic [ADDR_W-1:0] read_addr;
    logic [CHAR_W-1:0] read_data;

    assign h_wrap = (h_count == H_MAX);

    always_ff @(posedge clock_25Mhz) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else begin
            h_count <= h_wrap ? 10'd0 : h_count + 10'd1;
            if (h_wrap) begin
                v_count <= (v_count == V_MAX) ? 10'd0 : v_count + 10'd1;
            end
        end
    end

    // Decoded from the same counter state the buffer read uses, so all outputs line up
    always_ff @(posedge clock_25Mhz) begin
        if (reset) begin
            timing_q <= TIMING_RESET;
        end else begin
            timing_q.horiz_sync  <= !((h_count >= H_SYN_S) && (h_count < H_SYN_E));
            timing_q.vert_sync   <= !((v_count >= V_SYN_S) && (v_count < V_SYN_E));
            timing_q.video_on    <= (h_count < H_VIS) && (v_count < V_VIS);
            timing_q.frame_start <= (h_count == 10'd0) && (v_count == 10'd0);
            timing_q.font_row    <= v_count[3:1];
            timing_q.font_col    <= h_count[3:1];
        end
    end

    assign write_ok   = wr_en && !reset
                        && (wr_col < 6'(TEXT_COLS)) && (wr_row < 5'(TEXT_ROWS));
    assign write_addr = cell_address(wr_row, wr_col);
    assign read_addr  = cell_address(v_count[8:4], h_count[9:4]);

    screen_ram #(
        .DEPTH (CELLS)
    ) u_screen_ram (
        .clock_25Mhz (clock_25Mhz),
        .wr_en       (write_ok),
        .wr_addr     (write_addr),
        .wr_data     (wr_char),
        .rd_addr     (read_addr),
        .rd_data     (read_data)
    );

    assign character_address = timing_q.video_on ? read_data : '0;
    assign font_row          = timing_q.font_row;
    assign font_col          = timing_q.font_col;
    assign horiz_sync        = timing_q.horiz_sync;
    assign vert_sync         = timing_q.vert_sync;
    assign video_on          = timing_q.video_on;
    assign frame_start       = timing_q.frame_start;

endmodule
